// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with almost-full/empty thresholds, optional
// first-word-fall-through read mode and sticky overflow/underflow flags.
module param_sync_fifo #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned AF_THRESH = 12,
   parameter int unsigned AE_THRESH = 2,
   parameter int unsigned FWFT      = 0,
   localparam int unsigned PW       = $clog2(DEPTH),
   localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [CW-1:0]    count,
   output logic             overflow,
   output logic             underflow,
   input  logic             clr_err
);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;
   logic             wr_acc, rd_acc;

   assign full         = (count_q == DEPTH_C);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= AF_C);
   assign almost_empty = (count_q <= AE_C);
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   // Acceptance is judged on the pre-edge occupancy only.
   assign wr_acc = wr_en && !full;
   assign rd_acc = rd_en && !empty;

   always_comb begin
      count_d = count_q;
      unique case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      // A new error event wins over a simultaneous clear.
      overflow_d  = (wr_en && full)  ? 1'b1 : (clr_err ? 1'b0 : overflow_q);
      underflow_d = (rd_en && empty) ? 1'b1 : (clr_err ? 1'b0 : underflow_q);
   end

   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr_q] <= wr_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (rd_acc) rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign rd_data  = empty ? '0 : mem[rd_ptr_q];
         assign rd_valid = !empty;
      end else begin : g_std
         logic [WIDTH-1:0] rd_data_q;
         logic             rd_valid_q;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               rd_data_q  <= '0;
               rd_valid_q <= 1'b0;
            end else begin
               rd_valid_q <= rd_acc;
               if (rd_acc) rd_data_q <= mem[rd_ptr_q];
            end
         end

         assign rd_data  = rd_data_q;
         assign rd_valid = rd_valid_q;
      end
   endgenerate

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo: a standard-mode and an FWFT instance share stimulus
// and are checked every cycle against a queue model, plus directed literal checks.
module tb_param_sync_fifo;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
   logic [7:0] wr_data = 8'h00;

   logic [7:0] s_rd_data, f_rd_data;
   logic       s_rd_valid, f_rd_valid;
   logic       s_full, s_empty, s_af, s_ae, s_ov, s_un;
   logic       f_full, f_empty, f_af, f_ae, f_ov, f_un;
   logic [4:0] s_count, f_count;

   int n_chk = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   param_sync_fifo #(.WIDTH(8), .DEPTH(DEPTH), .AF_THRESH(12), .AE_THRESH(2), .FWFT(0)) dut_s (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
      .almost_full(s_af), .almost_empty(s_ae), .count(s_count), .overflow(s_ov),
      .underflow(s_un), .clr_err(clr_err)
   );

   param_sync_fifo #(.WIDTH(8), .DEPTH(DEPTH), .AF_THRESH(12), .AE_THRESH(2), .FWFT(1)) dut_f (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
      .almost_full(f_af), .almost_empty(f_ae), .count(f_count), .overflow(f_ov),
      .underflow(f_un), .clr_err(clr_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: occupancy is simply the queue length.
   logic [7:0] q[$];
   logic [7:0] exp_sd;
   bit         exp_sv, exp_ov, exp_un;

   always @(posedge clk or negedge reset) begin
      bit was_full, was_empty;
      if (!reset) begin
         q.delete();
         exp_sd = 8'h00;
         exp_sv = 1'b0;
         exp_ov = 1'b0;
         exp_un = 1'b0;
      end else begin
         was_full  = (q.size() == DEPTH);
         was_empty = (q.size() == 0);
         exp_ov = (wr_en && was_full) || (exp_ov && !clr_err);
         exp_un = (rd_en && was_empty) || (exp_un && !clr_err);
         exp_sv = rd_en && !was_empty;
         if (exp_sv) exp_sd = q.pop_front();
         if (wr_en && !was_full) q.push_back(wr_data);
      end
   end

   always @(negedge clk) begin
      int n;
      if (chk_en) begin
         n = q.size();
         chk("s_count", 32'(s_count), n);
         chk("f_count", 32'(f_count), n);
         chk("s_full", 32'(s_full), 32'(n == DEPTH));
         chk("f_full", 32'(f_full), 32'(n == DEPTH));
         chk("s_empty", 32'(s_empty), 32'(n == 0));
         chk("f_empty", 32'(f_empty), 32'(n == 0));
         chk("s_almost_full", 32'(s_af), 32'(n >= 12));
         chk("f_almost_full", 32'(f_af), 32'(n >= 12));
         chk("s_almost_empty", 32'(s_ae), 32'(n <= 2));
         chk("f_almost_empty", 32'(f_ae), 32'(n <= 2));
         chk("s_overflow", 32'(s_ov), 32'(exp_ov));
         chk("f_overflow", 32'(f_ov), 32'(exp_ov));
         chk("s_underflow", 32'(s_un), 32'(exp_un));
         chk("f_underflow", 32'(f_un), 32'(exp_un));
         chk("s_rd_valid", 32'(s_rd_valid), 32'(exp_sv));
         chk("s_rd_data", 32'(s_rd_data), 32'(exp_sd));
         chk("f_rd_valid", 32'(f_rd_valid), 32'(n != 0));
         chk("f_rd_data", 32'(f_rd_data), (n != 0) ? 32'(q[0]) : 32'h0);
      end
   end

   // Apply inputs away from the edge, then return just after the next rising edge.
   task automatic cyc(input bit w, input logic [7:0] d, input bit r, input bit c);
      @(negedge clk);
      #1;
      wr_en = w; wr_data = d; rd_en = r; clr_err = c;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1 reset = 1'b0;
      chk_en = 1'b1;
      #1;
      chk("rst_count", 32'(s_count), 32'h0);
      chk("rst_empty", 32'(s_empty), 32'h1);
      chk("rst_ae", 32'(s_ae), 32'h1);
      chk("rst_rd_valid", 32'(s_rd_valid), 32'h0);
      chk("rst_ov_un", {s_ov, s_un, f_ov, f_un}, 32'h0);
      #20 reset = 1'b1;

      // Fill to full; almost_full from the 12th write on.
      for (int i = 1; i <= 16; i++) begin
         cyc(1'b1, 8'(i), 1'b0, 1'b0);
         chk("fill_count", 32'(s_count), i);
         chk("fill_af", 32'(s_af), 32'(i >= 12));
      end
      chk("fill_full", 32'(s_full), 32'h1);
      chk("fwft_head", 32'(f_rd_data), 32'h01);

      cyc(1'b1, 8'hAA, 1'b0, 1'b0);
      chk("ovf_set", 32'(s_ov), 32'h1);
      chk("ovf_count", 32'(s_count), 32'd16);
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      chk("ovf_clr", 32'(s_ov), 32'h0);

      for (int i = 1; i <= 16; i++) begin
         cyc(1'b0, 8'h00, 1'b1, 1'b0);
         chk("drain_data", 32'(s_rd_data), i);
         chk("drain_valid", 32'(s_rd_valid), 32'h1);
      end
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      chk("drain_pulse", 32'(s_rd_valid), 32'h0);
      chk("drain_empty", 32'(s_empty), 32'h1);

      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("unf_set", 32'(s_un), 32'h1);
      chk("unf_valid", 32'(s_rd_valid), 32'h0);
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      chk("unf_clr", 32'(s_un), 32'h0);

      // Steady occupancy of 5 across pointer wrap.
      for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         cyc(1'b1, 8'($urandom), 1'b1, 1'b0);
         if (i == 0) chk("wrap_first", 32'(s_rd_data), 32'h30);
      end
      chk("wrap_count", 32'(s_count), 32'd5);
      for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

      cyc(1'b1, 8'h5A, 1'b0, 1'b0);
      chk("fwft_data", 32'(f_rd_data), 32'h5A);
      chk("fwft_valid", 32'(f_rd_valid), 32'h1);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("fwft_pop_empty", 32'(f_empty), 32'h1);
      chk("fwft_pop_data", 32'(f_rd_data), 32'h0);

      // Random traffic including error events colliding with clears.
      for (int i = 0; i < 400; i++) begin
         int mode;
         mode = (i / 100) % 2;
         cyc(($urandom_range(99) < (mode ? 70 : 35)), 8'($urandom),
             ($urandom_range(99) < (mode ? 35 : 70)), ($urandom_range(99) < 8));
      end

      for (int i = 0; i < 20; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("pre_rst_count", 32'(s_count), 32'd7);
      chk("pre_rst_valid", 32'(s_rd_valid), 32'h1);
      @(negedge clk);
      wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
      #1 reset = 1'b0;
      #1;
      chk("mid_rst_count", 32'(s_count), 32'h0);
      chk("mid_rst_valid", {s_rd_valid, f_rd_valid}, 32'h0);
      chk("mid_rst_data", {s_rd_data, f_rd_data}, 32'h0);
      chk("mid_rst_empty", {s_empty, f_empty, s_full}, 32'b110);
      #1 reset = 1'b1;
      for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h71 + i), 1'b0, 1'b0);
      chk("post_rst_fwft", 32'(f_rd_data), 32'h71);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 8'h00, 1'b1, 1'b0);
         chk("post_rst_data", 32'(s_rd_data), 32'(8'h71 + i));
      end
      cyc(1'b0, 8'h00, 1'b0, 1'b0);

      @(posedge clk);
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
